// File: rtl/mem_arbiter.sv
// Shares a 16-bit word memory between fetch (p0) and load/store (p1) ports.
// Odd-address words are split into two byte-lane accesses; byte reads are extended.
module mem_arbiter #(
    parameter int unsigned MAX_STREAK = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p0_req,
    input  logic [15:0] p0_addr,
    output logic        p0_ack,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic        p1_word,
    input  logic        p1_sext,
    input  logic [15:0] p1_addr,
    input  logic [15:0] p1_wdata,
    output logic        p1_ack,
    output logic [15:0] rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [1:0]  mem_be,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    output logic        busy
);
    localparam int unsigned SW = $clog2(MAX_STREAK + 1);

    typedef enum logic [1:0] {StIdle, StAcc1, StAcc2, StResp} state_e;

    state_e        state_q;
    logic [SW-1:0] streak_q;
    logic          gnt_q;
    logic          we_q;
    logic          word_q;
    logic          sext_q;
    logic [15:0]   addr_q;
    logic [15:0]   wdata_q;
    logic [7:0]    temp_q;
    logic [15:0]   rdata_q;
    logic          p0_ack_q;
    logic          p1_ack_q;

    logic          p0_force;
    logic          p1_win;
    logic          split;
    logic [7:0]    byte_sel;
    logic [15:0]   byte_ext;

    assign p0_force = p0_req && (streak_q == SW'(MAX_STREAK));
    assign p1_win   = p1_req && !p0_force;
    assign split    = word_q && addr_q[0];
    assign byte_sel = addr_q[0] ? mem_rdata[15:8] : mem_rdata[7:0];
    assign byte_ext = {{8{sext_q & byte_sel[7]}}, byte_sel};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            streak_q <= '0;
            gnt_q    <= 1'b0;
            we_q     <= 1'b0;
            word_q   <= 1'b0;
            sext_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            temp_q   <= '0;
            rdata_q  <= '0;
            p0_ack_q <= 1'b0;
            p1_ack_q <= 1'b0;
        end else begin
            p0_ack_q <= 1'b0;
            p1_ack_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (p1_win) begin
                        gnt_q   <= 1'b1;
                        we_q    <= p1_we;
                        word_q  <= p1_word;
                        sext_q  <= p1_sext;
                        addr_q  <= p1_addr;
                        wdata_q <= p1_wdata;
                        // p1 cannot win at the cap while p0 waits, so this never overflows
                        streak_q <= p0_req ? streak_q + 1'b1 : '0;
                        state_q  <= StAcc1;
                    end else if (p0_req) begin
                        gnt_q    <= 1'b0;
                        we_q     <= 1'b0;
                        word_q   <= 1'b1;
                        sext_q   <= 1'b0;
                        addr_q   <= p0_addr;
                        wdata_q  <= '0;
                        streak_q <= '0;
                        state_q  <= StAcc1;
                    end else begin
                        streak_q <= '0;
                    end
                end
                StAcc1: begin
                    if (mem_ready) begin
                        if (split) begin
                            temp_q  <= mem_rdata[15:8];
                            state_q <= StAcc2;
                        end else begin
                            if (!we_q) rdata_q <= word_q ? mem_rdata : byte_ext;
                            p0_ack_q <= !gnt_q;
                            p1_ack_q <= gnt_q;
                            state_q  <= StResp;
                        end
                    end
                end
                StAcc2: begin
                    if (mem_ready) begin
                        if (!we_q) rdata_q <= {mem_rdata[7:0], temp_q};
                        p0_ack_q <= !gnt_q;
                        p1_ack_q <= gnt_q;
                        state_q  <= StResp;
                    end
                end
                StResp: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        mem_req   = (state_q == StAcc1) || (state_q == StAcc2);
        mem_we    = 1'b0;
        mem_be    = 2'b00;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state_q == StAcc1) begin
            mem_we   = we_q;
            mem_addr = {addr_q[15:1], 1'b0};
            if (split) begin
                mem_be    = 2'b10;
                mem_wdata = {wdata_q[7:0], 8'h00};
            end else if (word_q) begin
                mem_be    = 2'b11;
                mem_wdata = wdata_q;
            end else begin
                mem_be    = addr_q[0] ? 2'b10 : 2'b01;
                mem_wdata = {2{wdata_q[7:0]}};
            end
        end else if (state_q == StAcc2) begin
            mem_we    = we_q;
            mem_addr  = addr_q + 16'd1;
            mem_be    = 2'b01;
            mem_wdata = {8'h00, wdata_q[15:8]};
        end
    end

    assign p0_ack = p0_ack_q;
    assign p1_ack = p1_ack_q;
    assign rdata  = rdata_q;
    assign busy   = (state_q != StIdle);

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequences and shares the 16-bit, word-organised memory port between the instruction-fetch port (p0) and the load/store port (p1). Each request is broken into one memory access, or two for odd-address words. The block packs byte lanes, sign- or zero-extends bytes and returns the result through a req/ack handshake. It sits between the core's fetch and execute units and the memory, and replaces per-cycle clock inhibiting with an explicit two-access sequence.

## Interface
Parameters:
- MAX_STREAK, default 4: consecutive p1 grants allowed while p0 waits before p0 is forced through.

Ports:
- clk  in  1  system clock; all state on rising edge
- reset  in  1  synchronous, active-high
- p0_req  in  1  fetch request; held until p0_ack
- p0_addr  in  16  fetch byte address (word read, may be odd)
- p0_ack  out  1  one-cycle pulse; rdata valid for p0
- p1_req  in  1  load/store request; held until p1_ack
- p1_we  in  1  1 = write
- p1_word  in  1  1 = 16-bit, 0 = byte
- p1_sext  in  1  byte reads: 1 = sign-extend, 0 = zero-extend
- p1_addr  in  16  byte address
- p1_wdata  in  16  write data (byte writes use [7:0])
- p1_ack  out  1  one-cycle pulse; rdata valid for p1 reads
- rdata  out  16  read result, shared; held until next ack
- mem_req  out  1  memory access active
- mem_we  out  1  memory write
- mem_be  out  2  byte enables; bit0 = [7:0] (even byte), bit1 = [15:8] (odd byte)
- mem_addr  out  16  byte address, bit0 always 0
- mem_wdata  out  16  lane-positioned write data
- mem_rdata  in  16  memory read word, valid when mem_ready
- mem_ready  in  1  access complete; wait states allowed
- busy  out  1  state != IDLE

## Operation
- Little-endian: byte at even address is lane [7:0], odd address is lane [15:8].
- States: IDLE, ACC1, ACC2, RESP.
  - IDLE: arbitrate and latch the winner's command. Go to ACC1.
  - ACC1: drive the first access. On mem_ready: aligned or byte → RESP; odd-address word → ACC2.
  - ACC2: drive the second access. On mem_ready → RESP.
  - RESP: assert the granted port's ack. Go to IDLE.
- Arbitration in IDLE:
  - p1 has priority.
  - If p0_req is high and streak == MAX_STREAK, p0 wins.
  - streak increments on a p1 grant while p0_req is high; saturates at MAX_STREAK.
  - streak clears on a p0 grant, or in IDLE when p0_req is low.
- Aligned word: one access, be=11, wdata passed straight through, rdata = mem_rdata.
- Byte access:
  - be selects the lane by addr[0]; wdata byte is replicated into both lanes.
  - Read selects the lane, then extends by p1_sext.
- Odd word (p0 always word):
  - ACC1: addr-1, be=10, lane[15:8] = wdata[7:0]; read captures mem_rdata[15:8] into an 8-bit temp.
  - ACC2: addr+1, be=01, lane[7:0] = wdata[15:8].
  - rdata = {mem_rdata[7:0], temp}.
- Address arithmetic is modulo 2^16: word at 0xFFFF uses ACC1 = 0xFFFE and ACC2 = 0x0000.
- mem_ready is ignored outside ACC1/ACC2.
- Command inputs are latched at grant; later changes are ignored until ack.

## Timing
- Reset values: state IDLE, streak 0, temp 0, rdata 0. All of p0_ack, p1_ack, mem_req, mem_we, mem_be, mem_addr, mem_wdata and busy are 0.
- mem_req, mem_we, mem_be, mem_addr and mem_wdata decode from registered state and latched command only. mem_be, mem_addr and mem_wdata are 0 when mem_req=0.
- Zero-wait latency, counted from the cycle req is sampled in IDLE (cycle 0):
  - aligned/byte: mem_req in cycle 1, ack in cycle 2;
  - odd word: accesses in cycles 1 and 2, ack in cycle 3.
- Each wait cycle (mem_ready=0) holds ACC1/ACC2 and adds one cycle.
- The requester drops req or presents a new command in the cycle after ack. IDLE is one cycle, so back-to-back issue rate is one request per 3 cycles (aligned).
- Simultaneous p0/p1 requests in IDLE: resolved by the priority and streak rule; the loser keeps waiting, with no ack.
- Reset mid-access: return to IDLE next cycle, no ack, abandon the access; mem_ready arriving after reset is ignored.

## Test plan
- Aligned p1 read: addr 0x0010, mem_rdata 0xBEEF with zero wait → mem_addr 0x0010, be=11 in cycle 1; p1_ack and rdata 0xBEEF in cycle 2.
- Byte reads: odd addr 0x0021, mem_rdata 0x80AA:
  - p1_sext=1 → 0xFF80;
  - p1_sext=0 → 0x0080.
- Unaligned word write: addr 0x0033, wdata 0x1234:
  - access 1: addr 0x0032, be=10, wdata[15:8]=0x34;
  - access 2: addr 0x0034, be=01, wdata[7:0]=0x12;
  - ack in cycle 3.
- Unaligned fetch at wrap: p0 addr 0xFFFF, words 0xAB00 then 0x00CD, 2 wait cycles on each access → addresses 0xFFFE then 0x0000; rdata 0xCDAB; ack in cycle 7.
- Starvation: p0_req and p1_req held high continuously with p1 re-requesting → grants p1,p1,p1,p1,p0, then streak clears and p1 wins again.
- Reset in ACC2 of an odd read → next cycle IDLE, mem_req 0, no ack; a late mem_ready is ignored; the next aligned request completes normally.
